// File: rtl/lorenz_param_loader.sv
// Lorenz solver parameter loader.
// Debounces a PIO parameter word (signed 7.20 fixed point), clamps it to a
// legal range and hands it to the solver only on an integration step boundary.
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   pio_in        raw parameter word from the PIO out_port
//   step_boundary one-cycle pulse when a solver integration step completes
//   param_out     clamped parameter currently applied to the solver
//   param_load    one-cycle strobe: param_out changed this cycle
//   pending       a new word is settling or waiting for a step boundary
//   clamped       last loaded value was clamped
//   load_count    number of loads since reset, wraps modulo 2^16
module lorenz_param_loader #(
  parameter int unsigned      WIDTH         = 27,
  parameter int unsigned      SETTLE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = 27'h0A00000,
  parameter logic [WIDTH-1:0] MIN_VAL       = 27'h0000000,
  parameter logic [WIDTH-1:0] MAX_VAL       = 27'h3200000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pio_in,
  input  logic             step_boundary,
  output logic [WIDTH-1:0] param_out,
  output logic             param_load,
  output logic             pending,
  output logic             clamped,
  output logic [15:0]      load_count
);

  localparam int unsigned    CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    WAIT_STEP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   accepted_q;
  logic [WIDTH-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               load_c;
  logic               below_c, above_c;
  logic [WIDTH-1:0]   clamp_val_c;

  // Word on the PIO differs from the candidate currently being tracked
  logic cand_diff_c;
  assign cand_diff_c = (pio_in != cand_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a PIO change in WAIT_STEP wins over a simultaneous step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pio_in != accepted_q) state_d = SETTLE;
      end
      SETTLE: begin
        if (!cand_diff_c && (cnt_q == CNT_LAST)) begin
          state_d = (cand_q == accepted_q) ? IDLE : WAIT_STEP;
        end
      end
      WAIT_STEP: begin
        if (cand_diff_c)        state_d = SETTLE;
        else if (step_boundary) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Candidate tracking, settle counter and load decision
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    load_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (pio_in != accepted_q) begin
          cand_d = pio_in;
          cnt_d  = '0;
        end
      end
      SETTLE: begin
        if (cand_diff_c) begin
          cand_d = pio_in;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_STEP: begin
        if (cand_diff_c) begin
          cand_d = pio_in;
          cnt_d  = '0;
        end else if (step_boundary) begin
          load_c = 1'b1;
        end
      end
      default: begin
        cand_d = cand_q;
        cnt_d  = '0;
      end
    endcase
  end

  // Signed clamp of the settled candidate
  always_comb begin
    below_c     = ($signed(cand_q) < $signed(MIN_VAL));
    above_c     = ($signed(cand_q) > $signed(MAX_VAL));
    clamp_val_c = cand_q;
    if (below_c)      clamp_val_c = MIN_VAL;
    else if (above_c) clamp_val_c = MAX_VAL;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accepted_q <= RESET_VALUE;
      cand_q     <= RESET_VALUE;
      cnt_q      <= '0;
      param_out  <= RESET_VALUE;
      param_load <= 1'b0;
      pending    <= 1'b0;
      clamped    <= 1'b0;
      load_count <= '0;
    end else begin
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      param_load <= load_c;
      pending    <= (state_d != IDLE);
      if (load_c) begin
        accepted_q <= cand_q;
        param_out  <= clamp_val_c;
        clamped    <= below_c | above_c;
        load_count <= load_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_lorenz_param_loader.sv
// Scoreboard bench for lorenz_param_loader: stimulus pushes expected loads,
// a monitor pops and compares on every param_load strobe.
module tb_lorenz_param_loader;

  localparam int unsigned W = 27;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  pio_in;
  logic          step_boundary;
  logic [W-1:0]  param_out;
  logic          param_load;
  logic          pending;
  logic          clamped;
  logic [15:0]   load_count;

  typedef struct {
    logic [W-1:0] val;
    logic         cl;
    logic [15:0]  cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          pulses   = 0;
  int          n_loads  = 0;
  logic [15:0] exp_cnt  = '0;
  logic        prev_load = 1'b0;

  lorenz_param_loader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pio_in       (pio_in),
    .step_boundary(step_boundary),
    .param_out    (param_out),
    .param_load   (param_load),
    .pending      (pending),
    .clamped      (clamped),
    .load_count   (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every strobe must match the oldest expected load
  always @(negedge clk) begin
    if (reset_n === 1'b1 && param_load === 1'b1) begin
      exp_t e;
      pulses++;
      check("load_pulse_width", 32'(prev_load), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_load: got param_out 0x%0h with no load expected at %0t",
                 param_out, $time);
      end else begin
        e = exp_q.pop_front();
        check("load_param_out", 32'(param_out), 32'(e.val));
        check("load_clamped", 32'(clamped), 32'(e.cl));
        check("load_count", 32'(load_count), 32'(e.cnt));
      end
    end
    prev_load = param_load;
  end

  // Apply a word, let it settle, then pulse step_boundary and expect a load
  task automatic do_load(input logic [W-1:0] v, input logic [W-1:0] eo, input logic ec,
                         input int wait_cyc);
    exp_t e;
    pio_in = v;
    repeat (wait_cyc) @(negedge clk);
    check("pending_before_step", 32'(pending), 32'd1);
    exp_cnt = exp_cnt + 16'd1;
    e.val = eo; e.cl = ec; e.cnt = exp_cnt;
    exp_q.push_back(e);
    n_loads++;
    step_boundary = 1'b1;
    @(negedge clk);
    step_boundary = 1'b0;
    @(negedge clk);
    check("pending_after_load", 32'(pending), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n       = 1'b0;
    pio_in        = 27'h0A00000;
    step_boundary = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_param_out", 32'(param_out), 32'h0A00000);
    check("rst_param_load", 32'(param_load), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_clamped", 32'(clamped), 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);

    // Glitch: 2 cycles of a new word, then back; steps every 3 cycles
    pio_in = 27'h1C00000;
    repeat (2) @(negedge clk);
    pio_in = 27'h0A00000;
    for (int i = 0; i < 15; i++) begin
      step_boundary = (i % 3 == 0);
      @(negedge clk);
    end
    step_boundary = 1'b0;
    check("glitch_param_out", 32'(param_out), 32'h0A00000);
    check("glitch_pending", 32'(pending), 32'd0);
    check("glitch_load_count", 32'(load_count), 32'd0);

    // Normal load with step 10 cycles after the change
    do_load(27'h1C00000, 27'h1C00000, 1'b0, 10);

    // Clamping
    do_load(27'h7F00000, 27'h0000000, 1'b1, 6);
    do_load(27'h3C00000, 27'h3200000, 1'b1, 6);
    do_load(27'h0800000, 27'h0800000, 1'b0, 6);

    // Simultaneous change and step in WAIT_STEP: no load, re-settle
    pio_in = 27'h1C00000;
    repeat (5) @(negedge clk);
    check("sim_pending_wait", 32'(pending), 32'd1);
    pio_in        = 27'h1000000;
    step_boundary = 1'b1;
    @(negedge clk);
    step_boundary = 1'b0;
    check("sim_no_load_out", 32'(param_out), 32'h0800000);
    check("sim_pending_resettle", 32'(pending), 32'd1);
    do_load(27'h1000000, 27'h1000000, 1'b0, 5);

    // Asynchronous reset in the middle of a settle
    pio_in = 27'h2000000;
    repeat (3) @(negedge clk);
    check("mid_pending", 32'(pending), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_param_out", 32'(param_out), 32'h0A00000);
    check("arst_param_load", 32'(param_load), 32'd0);
    check("arst_pending", 32'(pending), 32'd0);
    check("arst_clamped", 32'(clamped), 32'd0);
    check("arst_load_count", 32'(load_count), 32'd0);
    pio_in  = 27'h0A00000;
    exp_cnt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_pending", 32'(pending), 32'd0);
    check("post_rst_out", 32'(param_out), 32'h0A00000);

    // Back-to-back loads with alternating values
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) do_load(27'h0100000, 27'h0100000, 1'b0, 6);
      else            do_load(27'h0200000, 27'h0200000, 1'b0, 6);
    end

    // Jump the counter close to its wrap point, then cross it
    force dut.load_count = 16'hFFFE;
    @(negedge clk);
    release dut.load_count;
    exp_cnt = 16'hFFFE;
    do_load(27'h0100000, 27'h0100000, 1'b0, 6);
    do_load(27'h0200000, 27'h0200000, 1'b0, 6);
    check("wrap_load_count", 32'(load_count), 32'd0);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pulse_total", 32'(pulses), 32'(n_loads));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
